// File: rtl/secuenciador_mac_pkg.sv
// Shared constants for the FIR MAC sequencer: state encoding and Q-format widths.
package secuenciador_mac_pkg;

    localparam int unsigned Q_N    = 25;
    localparam int unsigned Q_FRAC = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CLEAR = 3'd2,
        MAC   = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/secuenciador_mac_if.sv
// Control/data bundle between the MAC sequencer and the FIR datapath.
interface secuenciador_mac_if
    import secuenciador_mac_pkg::*;
#(
    parameter int unsigned N  = Q_N,
    parameter int unsigned AW = 3
);
    logic                  start;
    logic signed [2*N-1:0] acum_in;
    logic [AW-1:0]         addr;
    logic                  shift_en;
    logic                  acc_clr;
    logic                  acc_en;
    logic [N-1:0]          y;
    logic                  y_valid;
    logic                  busy;
    logic                  overrun;

    modport master (
        output start, acum_in,
        input  addr, shift_en, acc_clr, acc_en, y, y_valid, busy, overrun
    );

    modport slave (
        input  start, acum_in,
        output addr, shift_en, acc_clr, acc_en, y, y_valid, busy, overrun
    );
endinterface

// File: rtl/secuenciador_mac_saturador.sv
// Combinational 2N->N conversion: drop FRAC fraction bits, saturate on overflow.
module saturador
    import secuenciador_mac_pkg::*;
#(
    parameter int unsigned N    = Q_N,
    parameter int unsigned FRAC = Q_FRAC
) (
    input  logic signed [2*N-1:0] acc_i,
    output logic        [N-1:0]   y_o
);
    localparam int unsigned HW = N - FRAC + 1;

    logic [HW-1:0] head;
    logic          unused_lsb;

    assign head       = acc_i[2*N-1 -: HW];
    assign unused_lsb = ^acc_i[FRAC-1:0];

    // Result fits when sign bit and all discarded upper bits agree.
    always_comb begin
        y_o = acc_i[FRAC+N-1:FRAC];
        if (!((&head) || !(|head))) begin
            y_o = acc_i[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
endmodule

// File: rtl/secuenciador_mac.sv
// Sequences one FIR output on the shared MAC datapath per accepted start pulse.
module secuenciador_mac
    import secuenciador_mac_pkg::*;
#(
    parameter int unsigned N    = Q_N,
    parameter int unsigned FRAC = Q_FRAC,
    parameter int unsigned TAPS = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    secuenciador_mac_if.slave  bus
);
    localparam int unsigned WW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    state_t         state_q;
    logic [AW-1:0]  addr_q;
    logic [WW-1:0]  wait_q;
    logic [LAT-1:0] pipe_q;
    logic           shift_en_q;
    logic           acc_clr_q;
    logic           y_valid_q;
    logic           busy_q;
    logic           overrun_q;
    logic [N-1:0]   y_q;
    logic [N-1:0]   y_sat;

    saturador #(.N(N), .FRAC(FRAC)) u_sat (
        .acc_i (bus.acum_in),
        .y_o   (y_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wait_q     <= '0;
            pipe_q     <= '0;
            shift_en_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            y_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            y_q        <= '0;
        end else begin
            shift_en_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            y_valid_q  <= 1'b0;
            // Tap-issued flag delayed to line up with product arrival.
            pipe_q     <= LAT'({pipe_q, state_q == MAC});
            if (bus.start && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= SHIFT;
                        shift_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    state_q   <= CLEAR;
                    acc_clr_q <= 1'b1;
                end
                CLEAR: begin
                    state_q <= MAC;
                    addr_q  <= '0;
                end
                MAC: begin
                    if (addr_q == AW'(TAPS - 1)) begin
                        state_q <= WAIT;
                        wait_q  <= '0;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                WAIT: begin
                    if (wait_q == WW'(LAT)) begin
                        state_q   <= DONE;
                        y_q       <= y_sat;
                        y_valid_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr     = addr_q;
    assign bus.shift_en = shift_en_q;
    assign bus.acc_clr  = acc_clr_q;
    assign bus.acc_en   = pipe_q[LAT-1];
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_secuenciador_mac.sv
// Directed bench for secuenciador_mac: timing, saturation, overrun, abort, TAPS=1/LAT=1.
module tb_secuenciador_mac;
    logic clk = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;
    logic ovr_exp;

    secuenciador_mac_if #(.N(25), .AW(3)) bus ();
    secuenciador_mac_if #(.N(25), .AW(1)) bus2 ();

    secuenciador_mac #(.N(25), .FRAC(10), .TAPS(8), .AW(3), .LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    secuenciador_mac #(.N(25), .FRAC(10), .TAPS(1), .AW(1), .LAT(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (cycle 0), then check cycles 1..14.
    task automatic run_seq(input logic signed [49:0] acc, input logic [24:0] exp_y,
                           input int ovr_at);
        bus.acum_in = acc;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            check($sformatf("shift_en@%0d", r), 64'(bus.shift_en), 64'(r == 1));
            check($sformatf("acc_clr@%0d", r), 64'(bus.acc_clr), 64'(r == 2));
            check($sformatf("acc_en@%0d", r), 64'(bus.acc_en), 64'(r >= 5 && r <= 12));
            check($sformatf("y_valid@%0d", r), 64'(bus.y_valid), 64'(r == 14));
            check($sformatf("busy@%0d", r), 64'(bus.busy), 64'(1));
            check($sformatf("overrun@%0d", r), 64'(bus.overrun), 64'(ovr_exp));
            if (r >= 3 && r <= 10)
                check($sformatf("addr@%0d", r), 64'(bus.addr), 64'(r - 3));
            if (r == 14)
                check("y", 64'(bus.y), 64'(exp_y));
            bus.start = (r == ovr_at);
            if (r < 14) step();
            if (r == ovr_at) ovr_exp = 1'b1;
        end
        bus.start = 1'b0;
        step();
        check("idle_y_valid", 64'(bus.y_valid), 64'(0));
        check("idle_busy", 64'(bus.busy), 64'(0));
        check("idle_addr_hold", 64'(bus.addr), 64'(7));
    endtask

    initial begin
        logic signed [49:0] a;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.acum_in  = '0;
        bus2.start   = 1'b0;
        bus2.acum_in = '0;
        ovr_exp      = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_addr", 64'(bus.addr), 64'(0));
        check("rst_shift_en", 64'(bus.shift_en), 64'(0));
        check("rst_acc_clr", 64'(bus.acc_clr), 64'(0));
        check("rst_acc_en", 64'(bus.acc_en), 64'(0));
        check("rst_y", 64'(bus.y), 64'(0));
        check("rst_y_valid", 64'(bus.y_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_overrun", 64'(bus.overrun), 64'(0));

        // First run with a stray start at cycle 7; next run begins at cycle 15.
        run_seq(50'sh1400, 25'd5, 7);
        a = 50'sd1 <<< 40;
        run_seq(a, 25'h0FFFFFF, 0);
        run_seq(-a, 25'h1000000, 0);
        run_seq(-50'sd1024, 25'h1FFFFFF, 0);

        // Abort at cycle 6.
        bus.acum_in = 50'sh2800;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int r = 1; r < 6; r++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_addr", 64'(bus.addr), 64'(0));
        check("abort_acc_en", 64'(bus.acc_en), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_overrun", 64'(bus.overrun), 64'(0));
        check("abort_y", 64'(bus.y), 64'(0));
        ovr_exp = 1'b0;
        for (int r = 0; r < 10; r++) begin
            check($sformatf("abort_no_valid@%0d", r), 64'(bus.y_valid), 64'(0));
            check($sformatf("abort_idle_busy@%0d", r), 64'(bus.busy), 64'(0));
            step();
        end
        run_seq(50'sh2800, 25'd10, 0);

        // TAPS=1, LAT=1 instance.
        bus2.acum_in = 50'sh1400;
        bus2.start   = 1'b1;
        step();
        bus2.start   = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            check($sformatf("s_shift_en@%0d", r), 64'(bus2.shift_en), 64'(r == 1));
            check($sformatf("s_acc_clr@%0d", r), 64'(bus2.acc_clr), 64'(r == 2));
            check($sformatf("s_acc_en@%0d", r), 64'(bus2.acc_en), 64'(r == 4));
            check($sformatf("s_y_valid@%0d", r), 64'(bus2.y_valid), 64'(r == 6));
            check($sformatf("s_busy@%0d", r), 64'(bus2.busy), 64'(r <= 6));
            if (r == 3) check("s_addr", 64'(bus2.addr), 64'(0));
            if (r == 6) check("s_y", 64'(bus2.y), 64'(5));
            step();
        end
        check("s_overrun", 64'(bus2.overrun), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
